// File: rtl/pipe_word_serializer_if.sv
// ---------------------------------------------------------------------------
// pipe_word_serializer_if
// Bundles the two handshakes of the word serializer.
//   enq side : enq__ENA / enq_v go in, enq__RDY comes back
//   out side : out__ENA / out_v / out_last go out, out__RDY comes back
// Modports:
//   master : the surrounding system (drives enq, consumes words)
//   slave  : the serializer itself
// ---------------------------------------------------------------------------
interface pipe_word_serializer_if #(
    parameter int WIDTH = 96,
    parameter int WORD  = 32
);
    logic             enq__ENA;
    logic [WIDTH-1:0] enq_v;
    logic             enq__RDY;
    logic             out__ENA;
    logic [WORD-1:0]  out_v;
    logic             out_last;
    logic             out__RDY;

    modport master (
        output enq__ENA, enq_v, out__RDY,
        input  enq__RDY, out__ENA, out_v, out_last
    );

    modport slave (
        input  enq__ENA, enq_v, out__RDY,
        output enq__RDY, out__ENA, out_v, out_last
    );
endinterface

// File: rtl/pipe_word_serializer.sv
// ---------------------------------------------------------------------------
// pipe_word_serializer
// Accepts whole WIDTH-bit messages, buffers up to DEPTH of them, and emits
// each one as WORD-bit words. Only the number of words named by the header
// length field (bits [15:0]) is sent; bad lengths are clamped and flagged.
// Ports:
//   CLK, nRST  : clock (rising edge), asynchronous active-low reset
//   bus        : enq and out handshakes (slave modport)
//   msg_count  : messages fully sent, wraps modulo 2^16
//   len_err    : sticky, set when a loaded header has N=0 or N>BEATS
// ---------------------------------------------------------------------------
module pipe_word_serializer #(
    parameter int WIDTH = 96,
    parameter int WORD  = 32,
    parameter int DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    pipe_word_serializer_if.slave bus,
    output logic [15:0]           msg_count,
    output logic                  len_err
);
    localparam int BEATS = WIDTH / WORD;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NW    = $clog2(BEATS + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shiftReg_q, shiftReg_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [NW-1:0]     neff_q, neff_d;
    logic [15:0]       msgCount_q, msgCount_d;
    logic              lenErr_q, lenErr_d;
    logic [PW-1:0]     wrPtr_q, rdPtr_q;
    logic [WIDTH-1:0]  fifoMem [DEPTH];

    logic [PW-1:0]     occupancy;
    logic              full, empty, enqAccept;
    logic [WIDTH-1:0]  headMsg;
    logic [15:0]       headLen;
    logic [NW-1:0]     headNeff;
    logic              headBad;
    logic              sending, lastBeat, xfer, lastXfer, load;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign occupancy = wrPtr_q - rdPtr_q;
    assign full      = (occupancy == PW'(DEPTH));
    assign empty     = (occupancy == '0);
    assign enqAccept = bus.enq__ENA & ~full;
    assign headMsg   = fifoMem[rdPtr_q[AW-1:0]];
    assign headLen   = headMsg[15:0];

    assign sending   = (state_q == SEND);
    assign lastBeat  = sending && ((NW'(beat_q) + NW'(1)) == neff_q);
    assign xfer      = sending & bus.out__RDY;
    assign lastXfer  = xfer & lastBeat;
    // The head is popped whenever the shift register is free or about to be.
    assign load      = ~empty & (~sending | lastXfer);

    assign bus.enq__RDY = ~full;
    assign bus.out__ENA = sending;
    assign bus.out_v    = sending ? shiftReg_q[WORD-1:0] : '0;
    assign bus.out_last = lastBeat;
    assign msg_count    = msgCount_q;
    assign len_err      = lenErr_q;

    // Clamp the header length into 1..BEATS and note whether clamping happened.
    always_comb begin
        headNeff = NW'(headLen);
        headBad  = 1'b0;
        if (headLen == 16'd0) begin
            headNeff = NW'(1);
            headBad  = 1'b1;
        end else if (headLen > 16'(BEATS)) begin
            headNeff = NW'(BEATS);
            headBad  = 1'b1;
        end
    end

    // Message storage; contents need no reset because pointers gate validity.
    always_ff @(posedge CLK) begin
        if (enqAccept) begin
            fifoMem[wrPtr_q[AW-1:0]] <= bus.enq_v;
        end
    end

    // FIFO pointers advance on accepted writes and on loads into the shifter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (enqAccept) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (load) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
        end
    end

    // Next-state logic: a transfer shifts the next word down, the final
    // transfer counts the message and either reloads or returns to IDLE.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        beat_d     = beat_q;
        neff_d     = neff_q;
        msgCount_d = msgCount_q;
        lenErr_d   = lenErr_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    shiftReg_d = shiftReg_q >> WORD;
                    beat_d     = beat_q + BW'(1);
                end
                if (lastXfer) begin
                    msgCount_d = msgCount_q + 16'd1;
                    if (!load) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            shiftReg_d = headMsg;
            beat_d     = '0;
            neff_d     = headNeff;
            lenErr_d   = lenErr_q | headBad;
        end
    end

    // State register for the sender.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            beat_q     <= '0;
            neff_q     <= '0;
            msgCount_q <= '0;
            lenErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            beat_q     <= beat_d;
            neff_q     <= neff_d;
            msgCount_q <= msgCount_d;
            lenErr_q   <= lenErr_d;
        end
    end
endmodule

// File: tb/tb_pipe_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_pipe_word_serializer
// Self-checking bench for pipe_word_serializer: table vectors, hand-written
// backpressure / reset / wrap sequences, and random traffic against a
// word-queue reference model.
// ---------------------------------------------------------------------------
module tb_pipe_word_serializer;
    logic        CLK;
    logic        nRST;
    logic [15:0] msg_count;
    logic        len_err;
    int          checks;
    int          errors;

    pipe_word_serializer_if #(.WIDTH(96), .WORD(32)) busIf ();

    pipe_word_serializer #(.WIDTH(96), .WORD(32), .DEPTH(2)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (busIf),
        .msg_count (msg_count),
        .len_err   (len_err)
    );

    // Free-running 10 ns clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [95:0] msg;
        int          nWords;
        logic        expErr;
    } vec_t;

    task automatic applyStimulus(input logic ena, input logic [95:0] v, input logic rdy);
        busIf.enq__ENA = ena;
        busIf.enq_v    = v;
        busIf.out__RDY = rdy;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One clock: outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        nRST = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    // Random traffic checked against a queue of expected {last, word} entries.
    task automatic randomTest(input int cycles);
        logic [32:0] expQ[$];
        logic [95:0] m;
        logic [15:0] modelCount;
        logic        errModel;
        logic        ena;
        logic        rdy;
        int          n;
        int          neff;
        modelCount = 16'd0;
        errModel   = 1'b0;
        for (int c = 0; c < cycles + 60; c++) begin
            m = {$urandom, $urandom, $urandom};
            n = $urandom_range(0, 5);
            m[15:0] = 16'(n);
            ena = (c < cycles) && ($urandom_range(0, 1) == 1) && busIf.enq__RDY;
            rdy = (c >= cycles) || ($urandom_range(0, 3) != 0);
            applyStimulus(ena, m, rdy);
            if (busIf.out__ENA) begin
                if (expQ.size() == 0) begin
                    checkOutput("rand_extra_word", 64'(busIf.out_v), 64'hDEAD);
                end else begin
                    checkOutput("rand_word", {31'd0, busIf.out_last, busIf.out_v}, 64'(expQ[0]));
                    if (rdy) begin
                        if (expQ[0][32]) modelCount = modelCount + 16'd1;
                        void'(expQ.pop_front());
                    end
                end
            end
            if (ena) begin
                neff = (n == 0) ? 1 : ((n > 3) ? 3 : n);
                if (n == 0 || n > 3) errModel = 1'b1;
                for (int i = 0; i < neff; i++) begin
                    expQ.push_back({(i == neff - 1), m[32*i +: 32]});
                end
            end
            step();
        end
        checkOutput("rand_drained", 64'(expQ.size()), 64'd0);
        checkOutput("rand_msg_count", 64'(msg_count), 64'(modelCount));
        checkOutput("rand_len_err", 64'(len_err), 64'(errModel));
    endtask

    initial begin
        vec_t        vecs[5];
        logic [95:0] mA[3];
        logic [95:0] m4;
        logic [31:0] expA[9];
        logic [31:0] prevWord;
        int          got;
        int          residual;
        int          accepted;
        logic        seenMax;
        logic        rdy;

        checks = 0;
        errors = 0;
        nRST   = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);

        // Reset state.
        doReset();
        checkOutput("reset_enq_rdy", 64'(busIf.enq__RDY), 64'd1);
        checkOutput("reset_out_ena", 64'(busIf.out__ENA), 64'd0);
        checkOutput("reset_out_v", 64'(busIf.out_v), 64'd0);
        checkOutput("reset_out_last", 64'(busIf.out_last), 64'd0);
        checkOutput("reset_msg_count", 64'(msg_count), 64'd0);
        checkOutput("reset_len_err", 64'(len_err), 64'd0);

        // Single messages with out__RDY held high.
        vecs[0] = '{msg: {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0003}, nWords: 3, expErr: 1'b0};
        vecs[1] = '{msg: {32'h11112222, 32'h33334444, 32'h00050001}, nWords: 1, expErr: 1'b0};
        vecs[2] = '{msg: {32'h55556666, 32'h77778888, 32'h12340002}, nWords: 2, expErr: 1'b0};
        vecs[3] = '{msg: {32'h9999AAAA, 32'hBBBBCCCC, 32'h99990000}, nWords: 1, expErr: 1'b1};
        vecs[4] = '{msg: {32'hDDDDEEEE, 32'hF0F0F0F0, 32'h77770007}, nWords: 3, expErr: 1'b1};
        for (int v = 0; v < 5; v++) begin
            applyStimulus(1'b1, vecs[v].msg, 1'b1);
            step();
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("vec_idle_after_enq", 64'(busIf.out__ENA), 64'd0);
            step();
            got = 0;
            for (int k = 0; k < 8; k++) begin
                if (busIf.out__ENA) begin
                    checkOutput("vec_contiguous", 64'(k), 64'(got));
                    if (got < vecs[v].nWords) begin
                        checkOutput("vec_word", 64'(busIf.out_v), 64'(vecs[v].msg[32*got +: 32]));
                        checkOutput("vec_last", 64'(busIf.out_last), 64'(got == vecs[v].nWords - 1));
                    end
                    got++;
                end
                step();
            end
            checkOutput("vec_word_count", 64'(got), 64'(vecs[v].nWords));
            checkOutput("vec_msg_count", 64'(msg_count), 64'(v + 1));
            checkOutput("vec_len_err", 64'(len_err), 64'(vecs[v].expErr));
        end

        // Reset in the middle of a 3-word message with a second one queued.
        applyStimulus(1'b1, {32'h33330003, 32'h22220003, 32'h11110003}, 1'b1);
        step();
        applyStimulus(1'b1, {32'h66660003, 32'h55550003, 32'h44440003}, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b1);
        step();
        step();
        checkOutput("mid_word2_shown", 64'(busIf.out_v), 64'h33330003);
        nRST = 1'b0;
        #1;
        checkOutput("mid_reset_out_ena", 64'(busIf.out__ENA), 64'd0);
        checkOutput("mid_reset_enq_rdy", 64'(busIf.enq__RDY), 64'd1);
        checkOutput("mid_reset_msg_count", 64'(msg_count), 64'd0);
        checkOutput("mid_reset_len_err", 64'(len_err), 64'd0);
        step();
        nRST = 1'b1;
        residual = 0;
        for (int k = 0; k < 10; k++) begin
            if (busIf.out__ENA) residual++;
            step();
        end
        checkOutput("mid_reset_no_residual", 64'(residual), 64'd0);

        // Backpressure: fill the FIFO, try an illegal write, then drain.
        doReset();
        mA[0] = {32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A00003};
        mA[1] = {32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B00003};
        mA[2] = {32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C00003};
        m4    = {32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D00003};
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 3; i++) expA[3*m + i] = mA[m][32*i +: 32];
        end
        applyStimulus(1'b1, mA[0], 1'b0);
        step();
        applyStimulus(1'b1, mA[1], 1'b0);
        step();
        checkOutput("bp_first_loaded", 64'(busIf.out__ENA), 64'd1);
        applyStimulus(1'b1, mA[2], 1'b0);
        step();
        checkOutput("bp_full_enq_rdy", 64'(busIf.enq__RDY), 64'd0);
        applyStimulus(1'b1, m4, 1'b0);
        step();
        checkOutput("bp_full_still", 64'(busIf.enq__RDY), 64'd0);
        checkOutput("bp_hold_word", 64'(busIf.out_v), 64'(expA[0]));
        applyStimulus(1'b0, '0, 1'b0);
        step();
        checkOutput("bp_hold_word2", 64'(busIf.out_v), 64'(expA[0]));
        got = 0;
        prevWord = busIf.out_v;
        for (int k = 0; k < 11 && got < 9; k++) begin
            rdy = !(k == 4 || k == 5);
            applyStimulus(1'b0, '0, rdy);
            if (k == 2) checkOutput("bp_no_bypass", 64'(busIf.enq__RDY), 64'd0);
            if (!busIf.out__ENA) begin
                checkOutput("bp_bubble", 64'(busIf.out__ENA), 64'd1);
            end else begin
                if (k == 5) checkOutput("bp_stall_stable", 64'(busIf.out_v), 64'(prevWord));
                if (rdy) begin
                    checkOutput("bp_word", 64'(busIf.out_v), 64'(expA[got]));
                    checkOutput("bp_last", 64'(busIf.out_last), 64'((got % 3) == 2));
                    got++;
                end
            end
            prevWord = busIf.out_v;
            step();
        end
        checkOutput("bp_word_count", 64'(got), 64'd9);
        checkOutput("bp_msg_count", 64'(msg_count), 64'd3);
        step();
        checkOutput("bp_no_fourth", 64'(busIf.out__ENA), 64'd0);
        checkOutput("bp_empty_rdy", 64'(busIf.enq__RDY), 64'd1);

        // Random traffic against the reference model.
        doReset();
        randomTest(1500);

        // Counter wrap with 65536 one-word messages.
        doReset();
        accepted = 0;
        seenMax  = 1'b0;
        for (int c = 0; c < 70000 && (accepted < 65536 || busIf.out__ENA); c++) begin
            applyStimulus(accepted < 65536, {64'd0, 32'h00000001}, 1'b1);
            if (busIf.enq__ENA && busIf.enq__RDY) accepted++;
            step();
            if (msg_count == 16'hFFFF) seenMax = 1'b1;
        end
        applyStimulus(1'b0, '0, 1'b1);
        repeat (3) step();
        checkOutput("wrap_accepted", 64'(accepted), 64'd65536);
        checkOutput("wrap_saw_ffff", 64'(seenMax), 64'd1);
        checkOutput("wrap_msg_count", 64'(msg_count), 64'd0);
        checkOutput("wrap_idle", 64'(busIf.out__ENA), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_word_serializer.md
Name: pipe_word_serializer

Overview:
- Downstream stage of a request/indication output proxy: accepts whole 96-bit pipe messages on an enq method and emits them as 32-bit words on an out method, toward a word-wide transport link.
- Buffers up to DEPTH whole messages in an internal FIFO.
- Sends only the number of words given by the length field in the message header.
- Keeps a sent-message counter and a sticky length-error flag.

Parameters:
- WIDTH, 96, message width in bits; must be a multiple of WORD.
- WORD, 32, output word width in bits.
- DEPTH, 2, message FIFO depth; power of two, at least 2.
- Derived: BEATS = WIDTH/WORD (3 at defaults).

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- enq__ENA  input  1  enq method enable; asserted only while enq__RDY is high.
- enq_v  input  WIDTH  message; bits [15:0] = word count N including the header word; bits [31:16] = method id.
- enq__RDY  output  1  FIFO not full.
- out__ENA  output  1  output word valid.
- out_v  output  WORD  output word.
- out_last  output  1  current word is the final word of its message.
- out__RDY  input  1  downstream accepts a word.
- msg_count  output  16  number of messages fully sent; wraps modulo 2^16.
- len_err  output  1  sticky; set when a message has N=0 or N>BEATS.

Behaviour:
- Reset (async assert, sync-safe deassert): FIFO empty, state IDLE, beat counter 0.
  - Output values at reset: enq__RDY=1, out__ENA=0, out_v=0, out_last=0, msg_count=0, len_err=0.
- Enq:
  - A message is written when enq__ENA=1.
  - enq__RDY = (occupancy < DEPTH) and is registered/derived from occupancy only.
  - When the FIFO is full, enq__RDY stays 0 even if a pop happens in the same cycle. There is no bypass path.
  - enq__ENA while enq__RDY=0 is illegal. The block ignores it and does not write.
- Length decode happens when the head message is loaded into the shift register:
  - Neff = N when 1 ≤ N ≤ BEATS.
  - N=0 gives Neff=1. N>BEATS gives Neff=BEATS. In both cases len_err sets in the cycle after the load.
- State machine IDLE/SEND:
  - IDLE to SEND: FIFO not empty. On the clock edge the head message is popped into the shift register, beat=0, and Neff is latched.
  - Minimum latency: a message enqueued at edge t into an empty, idle block has its first word on out_v with out__ENA=1 after edge t+1.
  - SEND: out__ENA=1 and out_v = msg[WORD*beat +: WORD]. out_last=1 when beat == Neff-1.
  - Word transfer: happens when out__ENA & out__RDY. Then beat increments. While out__RDY=0, out_v and out_last hold stable.
  - Transfer of the last word: msg_count increments. If the FIFO is non-empty, the next message loads on the same edge, so consecutive messages have no bubble. Otherwise the state returns to IDLE.
- Simultaneous enq and pop on the same edge:
  - Occupancy is unchanged.
  - Allowed whenever enq__RDY was 1 in that cycle.
- Counter wrap: msg_count goes 0xFFFF → 0x0000 with no flag.
- Reset mid-message: the partial message is dropped, no further words are emitted, and the FIFO is cleared.
- No combinational path from out__RDY to enq__RDY, and none from enq__ENA to out__ENA.
- Sizing: the shift register is WIDTH bits, the beat counter is clog2(BEATS) bits, and FIFO pointers are clog2(DEPTH)+1 bits.

Test Plan:
- Single message: enq_v = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0003} (header word 0 = 0xAAAA0003), out__RDY=1.
  - Words 0xAAAA0003, 0xBBBB0002, 0xCCCC0003 on 3 consecutive cycles, starting the cycle after enq.
  - out_last only on the third word. msg_count=1.
- Short message with header 0x00050001: exactly 1 word 0x00050001, out_last=1, len_err stays 0.
- Backpressure and full:
  - Setup: out__RDY=0; enqueue 3 messages back-to-back.
  - Message 1 loads into the shift register. Messages 2 and 3 fill the FIFO and enq__RDY drops to 0.
  - A 4th enq__ENA attempt is not written.
  - Releasing out__RDY: all words drain in order with no bubbles between messages, and msg_count=3.
  - Holding out__RDY low mid-message keeps out_v stable.
- Length errors:
  - Header N=0 → 1 word sent, len_err=1.
  - Header N=7 → 3 words sent, len_err stays 1 until reset.
- Wrap and reset:
  - Force 65536 one-word messages → msg_count reads 0.
  - Assert nRST after word 1 of a 3-word message → out__ENA=0 immediately, enq__RDY=1, msg_count=0, and no residual words after release.
